// File: rtl/uart_rx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_if
// Host-side register interface of the UART receiver.
//   rd_ack     : host read strobe, one clk wide (host -> receiver)
//   rx_data    : received byte, unused MSBs zero (receiver -> host)
//   rx_ready   : rx_data holds an unread byte
//   frame_err  : stop bit of the byte in rx_data sampled 0
//   parity_err : parity mismatch on the byte in rx_data
//   overrun    : sticky, a byte was dropped while rx_ready was still set
//   busy       : receiver is not idle
// master = host register file, slave = receiver.
// ---------------------------------------------------------------------------
interface uart_rx_frame_if;
   logic       rd_ack;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       frame_err;
   logic       parity_err;
   logic       overrun;
   logic       busy;

   modport master (
      output rd_ack,
      input  rx_data, rx_ready, frame_err, parity_err, overrun, busy
   );

   modport slave (
      input  rd_ack,
      output rx_data, rx_ready, frame_err, parity_err, overrun, busy
   );
endinterface

// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
// 16x-oversampling asynchronous serial receiver. Recovers start / data /
// optional parity / stop framing from rxd and holds the received byte with
// its frame/parity status until the host acknowledges it.
// Ports:
//   clk   : UART clock
//   rst   : asynchronous active-low reset
//   en_rx : oversample tick, one clk wide, 16 ticks per bit period
//   rxd   : serial line, idle high, asynchronous to clk
//   host  : host register interface (slave side), see uart_rx_frame_if
// ---------------------------------------------------------------------------
module uart_rx_frame #(
   parameter int DATA_BITS  = 8,   // 5..8, LSB first
   parameter int PARITY_EN  = 0,   // 1 = parity bit follows the data
   parameter int PARITY_ODD = 0    // 1 = odd parity, 0 = even
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en_rx,
   input  logic           rxd,
   uart_rx_frame_if.slave host
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
   } state_t;

   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);
   localparam logic       PAR_EN   = (PARITY_EN != 0);
   localparam logic       PAR_ODD  = (PARITY_ODD != 0);

   state_t     state_q, state_d;
   logic [3:0] tc_q, tc_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q, shift_d;
   logic       par_bit_q, par_bit_d;
   logic       sync_q, rxd_s_q;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_ready_q, rx_ready_d;
   logic       frame_err_q, frame_err_d;
   logic       parity_err_q, parity_err_d;
   logic       overrun_q, overrun_d;
   logic       deliver;
   logic       par_mismatch;

   // Even parity expects XOR(data, parity) = 0, odd expects 1.
   assign par_mismatch = (^shift_q) ^ par_bit_q ^ PAR_ODD;

   // ---------------- state register (plus datapath flops) ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         tc_q         <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         par_bit_q    <= 1'b0;
         sync_q       <= 1'b1;
         rxd_s_q      <= 1'b1;
         rx_data_q    <= '0;
         rx_ready_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tc_q         <= tc_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         par_bit_q    <= par_bit_d;
         sync_q       <= rxd;
         rxd_s_q      <= sync_q;
         rx_data_q    <= rx_data_d;
         rx_ready_q   <= rx_ready_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d   = state_q;
      tc_d      = tc_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      par_bit_d = par_bit_q;
      deliver   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en_rx && !rxd_s_q) begin
               state_d = ST_START;
               tc_d    = '0;
            end
         end
         ST_START: begin
            if (en_rx) begin
               if (tc_q == 4'd7) begin
                  // Mid start bit: a high line here means it was a glitch.
                  tc_d = '0;
                  if (!rxd_s_q) begin
                     state_d = ST_DATA;
                     idx_d   = '0;
                     shift_d = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  tc_d = tc_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (en_rx) begin
               tc_d = tc_q + 4'd1;   // wraps 15 -> 0 at each sample
               if (tc_q == 4'd15) begin
                  shift_d[idx_q] = rxd_s_q;
                  idx_d          = idx_q + 3'd1;
                  if (idx_q == LAST_IDX)
                     state_d = PAR_EN ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (en_rx) begin
               tc_d = tc_q + 4'd1;
               if (tc_q == 4'd15) begin
                  par_bit_d = rxd_s_q;
                  state_d   = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (en_rx) begin
               tc_d = tc_q + 4'd1;
               if (tc_q == 4'd15) begin
                  // Leave mid stop bit so a start edge right after is caught.
                  deliver = 1'b1;
                  state_d = rxd_s_q ? ST_IDLE : ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // Held-low line must return high before a new start is armed.
            if (rxd_s_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- host holding register ----------------
   always_comb begin
      rx_data_d    = rx_data_q;
      rx_ready_d   = rx_ready_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      overrun_d    = overrun_q;
      if (deliver) begin
         if (!rx_ready_q || host.rd_ack) begin
            rx_data_d    = shift_q;
            frame_err_d  = ~rxd_s_q;
            parity_err_d = PAR_EN & par_mismatch;
            rx_ready_d   = 1'b1;
         end else begin
            overrun_d = 1'b1;     // new byte is dropped
         end
         if (host.rd_ack) overrun_d = 1'b0;
      end else if (host.rd_ack) begin
         rx_ready_d = 1'b0;
         overrun_d  = 1'b0;
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      host.rx_data    = rx_data_q;
      host.rx_ready   = rx_ready_q;
      host.frame_err  = frame_err_q;
      host.parity_err = parity_err_q;
      host.overrun    = overrun_q;
      host.busy       = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
// Directed bench for uart_rx_frame: three instances (8N1, 8O1, 5N1), en_rx
// every 4 clk so one bit period is 64 clk.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] tick_cnt = 2'd0;
   logic       en_rx;
   logic       rxd_a = 1'b1;
   logic       rxd_p = 1'b1;
   logic       rxd_f = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   uart_rx_frame_if ifa ();
   uart_rx_frame_if ifp ();
   uart_rx_frame_if iff5 ();

   uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_a (
      .clk(clk), .rst(rst), .en_rx(en_rx), .rxd(rxd_a), .host(ifa));
   uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_p (
      .clk(clk), .rst(rst), .en_rx(en_rx), .rxd(rxd_p), .host(ifp));
   uart_rx_frame #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_f (
      .clk(clk), .rst(rst), .en_rx(en_rx), .rxd(rxd_f), .host(iff5));

   always #5 clk = ~clk;

   always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
   assign en_rx = (tick_cnt == 2'd0);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic drive_rxd(input int sel, input logic b);
      case (sel)
         0:       rxd_a = b;
         1:       rxd_p = b;
         default: rxd_f = b;
      endcase
   endtask

   task automatic hold_bit();
      repeat (64) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int sel, input logic [7:0] data, input int nbits,
                             input bit use_par, input logic par, input logic stop);
      drive_rxd(sel, 1'b0);
      hold_bit();
      for (int i = 0; i < nbits; i++) begin
         drive_rxd(sel, data[i]);
         hold_bit();
      end
      if (use_par) begin
         drive_rxd(sel, par);
         hold_bit();
      end
      drive_rxd(sel, stop);
      hold_bit();
   endtask

   // Step to just after a clock edge on which en_rx is sampled high.
   task automatic align();
      @(posedge clk iff en_rx);
      #1;
   endtask

   task automatic ack(input int sel);
      case (sel)
         0:       ifa.rd_ack  = 1'b1;
         1:       ifp.rd_ack  = 1'b1;
         default: iff5.rd_ack = 1'b1;
      endcase
      @(posedge clk);
      #1;
      ifa.rd_ack  = 1'b0;
      ifp.rd_ack  = 1'b0;
      iff5.rd_ack = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      ifa.rd_ack  = 1'b0;
      ifp.rd_ack  = 1'b0;
      iff5.rd_ack = 1'b0;

      // ---- reset state ----
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rx_ready", ifa.rx_ready, 0);
      check_eq("rst_rx_data", ifa.rx_data, 0);
      check_eq("rst_busy", ifa.busy, 0);
      check_eq("rst_overrun", ifa.overrun, 0);
      rst = 1'b1;
      repeat (8) @(posedge clk);
      #1;

      // ---- 0xA5, with latency: fall just after a tick edge, ready after 612 edges ----
      align();
      n = 0;
      fork
         send_frame(0, 8'hA5, 8, 0, 1'b0, 1'b1);
         begin
            while (!ifa.rx_ready && n < 800) begin
               @(posedge clk);
               #1;
               n++;
            end
         end
      join
      check_eq("a5_latency_in_range", (n >= 610 && n <= 616), 1);
      check_eq("a5_rx_data", ifa.rx_data, 8'hA5);
      check_eq("a5_rx_ready", ifa.rx_ready, 1);
      check_eq("a5_frame_err", ifa.frame_err, 0);
      check_eq("a5_parity_err", ifa.parity_err, 0);
      ack(0);
      check_eq("a5_ack_ready", ifa.rx_ready, 0);
      check_eq("a5_ack_data_kept", ifa.rx_data, 8'hA5);

      // ---- 2-tick glitch then real 0x3C ----
      align();
      rxd_a = 1'b0;
      repeat (8) @(posedge clk);
      #1 rxd_a = 1'b1;
      repeat (64) @(posedge clk);
      #1;
      check_eq("glitch_busy", ifa.busy, 0);
      check_eq("glitch_ready", ifa.rx_ready, 0);
      send_frame(0, 8'h3C, 8, 0, 1'b0, 1'b1);
      check_eq("3c_rx_data", ifa.rx_data, 8'h3C);
      check_eq("3c_rx_ready", ifa.rx_ready, 1);
      ack(0);

      // ---- overrun ----
      send_frame(0, 8'h11, 8, 0, 1'b0, 1'b1);
      send_frame(0, 8'h22, 8, 0, 1'b0, 1'b1);
      check_eq("ovr_rx_data", ifa.rx_data, 8'h11);
      check_eq("ovr_overrun", ifa.overrun, 1);
      check_eq("ovr_ready", ifa.rx_ready, 1);
      ack(0);
      check_eq("ovr_ack_overrun", ifa.overrun, 0);
      check_eq("ovr_ack_ready", ifa.rx_ready, 0);

      // ---- rd_ack coincident with the stop-sample edge (edge 612 after fall) ----
      send_frame(0, 8'h11, 8, 0, 1'b0, 1'b1);
      send_frame(0, 8'h33, 8, 0, 1'b0, 1'b1);
      check_eq("co_pre_overrun", ifa.overrun, 1);
      align();
      fork
         send_frame(0, 8'h22, 8, 0, 1'b0, 1'b1);
         begin
            repeat (611) @(posedge clk);
            #1;
            ack(0);
         end
      join
      check_eq("co_rx_data", ifa.rx_data, 8'h22);
      check_eq("co_ready", ifa.rx_ready, 1);
      check_eq("co_overrun", ifa.overrun, 0);

      // ---- reset during data bit 4 ----
      align();
      fork
         send_frame(0, 8'h55, 8, 0, 1'b0, 1'b1);
         begin
            repeat (352) @(posedge clk);
            #1 rst = 1'b0;
            #1;
            check_eq("mid_rst_data", ifa.rx_data, 0);
            check_eq("mid_rst_ready", ifa.rx_ready, 0);
            check_eq("mid_rst_busy", ifa.busy, 0);
            check_eq("mid_rst_flags", {ifa.overrun, ifa.frame_err, ifa.parity_err}, 0);
         end
      join
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      repeat (64) @(posedge clk);
      #1;
      check_eq("post_rst_ready", ifa.rx_ready, 0);
      check_eq("post_rst_busy", ifa.busy, 0);
      send_frame(0, 8'hC3, 8, 0, 1'b0, 1'b1);
      check_eq("c3_rx_data", ifa.rx_data, 8'hC3);
      check_eq("c3_flags", {ifa.rx_ready, ifa.overrun, ifa.frame_err, ifa.parity_err}, 4'b1000);
      ack(0);

      // ---- frame error with line held low ----
      send_frame(0, 8'h7E, 8, 0, 1'b0, 1'b0);
      check_eq("fe_rx_data", ifa.rx_data, 8'h7E);
      check_eq("fe_frame_err", ifa.frame_err, 1);
      check_eq("fe_ready", ifa.rx_ready, 1);
      check_eq("fe_busy", ifa.busy, 1);
      ack(0);
      repeat (40 * 64) @(posedge clk);
      #1;
      check_eq("fe_low_busy", ifa.busy, 1);
      check_eq("fe_low_ready", ifa.rx_ready, 0);
      rxd_a = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check_eq("fe_rise_busy", ifa.busy, 0);
      repeat (200) @(posedge clk);
      #1;
      check_eq("fe_no_spurious", {ifa.rx_ready, ifa.overrun}, 0);

      // ---- odd parity, 8 bits ----
      send_frame(1, 8'h03, 8, 1, 1'b1, 1'b1);
      check_eq("par_ok_data", ifp.rx_data, 8'h03);
      check_eq("par_ok_err", ifp.parity_err, 0);
      check_eq("par_ok_ready", ifp.rx_ready, 1);
      ack(1);
      send_frame(1, 8'h03, 8, 1, 1'b0, 1'b1);
      check_eq("par_bad_err", ifp.parity_err, 1);
      check_eq("par_bad_fe", ifp.frame_err, 0);
      ack(1);

      // ---- 5 data bits ----
      send_frame(2, 8'h1F, 5, 0, 1'b0, 1'b1);
      check_eq("db5_1f_data", iff5.rx_data, 8'h1F);
      check_eq("db5_1f_ready", iff5.rx_ready, 1);
      ack(2);
      send_frame(2, 8'hEA, 5, 0, 1'b0, 1'b1);
      check_eq("db5_0a_data", iff5.rx_data, 8'h0A);
      check_eq("db5_0a_fe", iff5.frame_err, 0);
      ack(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
